// File: rtl/ibus_icache.sv
// rtl/ibus_icache.sv - direct-mapped read-only instruction cache between IBus and CBus
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
package ibus_icache_pkg;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_type_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic            valid;
        logic            is_write;
        msize_t          size;
        logic [31:0]     addr;
        logic [7:0]      strobe;
        logic [63:0]     data;
        mlen_t           len;
        axi_burst_type_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module ibus_icache
    import ibus_icache_pkg::*;
#(
    parameter int NUM_LINES  = 4,
    parameter int LINE_BEATS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    output cbus_req_t  icreq,
    input  cbus_resp_t icresp,
    input  logic       flush
`ifdef ICACHE_STATS_EN
    ,
    output logic [63:0] hit_cnt,
    output logic [63:0] miss_cnt
`endif
);

    localparam int BEAT_W  = $clog2(LINE_BEATS);
    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int OFF_W   = BEAT_W + 1;
    localparam int IDX_LSB = 2 + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam mlen_t REFILL_LEN = (LINE_BEATS == 2) ? MLEN2 :
                                   (LINE_BEATS == 4) ? MLEN4 : MLEN8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REFILL   = 2'd1,
        UNCACHED = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [63:0]      data_mem [NUM_LINES*LINE_BEATS];
    logic [TAG_W-1:0] tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    logic [31:0]       req_addr_q;
    logic [BEAT_W-1:0] cnt_q;
    logic              flush_seen_q;

    logic [IDX_W-1:0]  lk_idx;
    logic [BEAT_W-1:0] lk_beat;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;
    logic [63:0]       lk_beat_data;
    logic [31:0]       lk_word;
    logic [IDX_W-1:0]  ref_idx;
    logic              addr_match;
    logic              unused_addr_bits;

    assign lk_idx       = ireq.addr[IDX_LSB +: IDX_W];
    assign lk_beat      = ireq.addr[3 +: BEAT_W];
    assign lk_tag       = ireq.addr[31:TAG_LSB];
    assign lk_hit       = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign lk_beat_data = data_mem[{lk_idx, lk_beat}];
    assign lk_word      = ireq.addr[2] ? lk_beat_data[63:32] : lk_beat_data[31:0];
    assign ref_idx      = req_addr_q[IDX_LSB +: IDX_W];
    assign addr_match   = (ireq.addr[31:2] == req_addr_q[31:2]);
    assign unused_addr_bits = ^ireq.addr[1:0];

    // Next state and the combinational response to the core.
    always_comb begin
        state_d = state_q;
        iresp   = '0;
        case (state_q)
            IDLE: begin
                if (ireq.valid) begin
                    if (!ireq.addr[31]) begin
                        state_d = UNCACHED;
                    end else if (lk_hit) begin
                        iresp.addr_ok = 1'b1;
                        iresp.data_ok = 1'b1;
                        iresp.data    = lk_word;
                    end else begin
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                if (icresp.ready && icresp.last) begin
                    state_d = IDLE;
                end
            end
            UNCACHED: begin
                if (icresp.ready) begin
                    state_d = IDLE;
                    // The core may have moved on; only answer the request we fetched for.
                    if (ireq.valid && addr_match) begin
                        iresp.addr_ok = 1'b1;
                        iresp.data_ok = 1'b1;
                        iresp.data    = req_addr_q[2] ? icresp.data[63:32] : icresp.data[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!reset) begin
            iresp = '0;
        end
    end

    // Bus request depends only on state and the latched address.
    always_comb begin
        icreq = '0;
        case (state_q)
            REFILL: begin
                icreq.valid = 1'b1;
                icreq.size  = MSIZE8;
                icreq.addr  = {req_addr_q[31:IDX_LSB], {IDX_LSB{1'b0}}};
                icreq.len   = REFILL_LEN;
                icreq.burst = AXI_BURST_INCR;
            end
            UNCACHED: begin
                icreq.valid = 1'b1;
                icreq.size  = MSIZE4;
                icreq.addr  = req_addr_q;
                icreq.len   = MLEN1;
                icreq.burst = AXI_BURST_INCR;
            end
            default: icreq = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            valid_q      <= '0;
            flush_seen_q <= 1'b0;
            req_addr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                valid_q <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (state_d != IDLE) begin
                        req_addr_q   <= ireq.addr;
                        cnt_q        <= '0;
                        flush_seen_q <= 1'b0;
                    end
                end
                REFILL: begin
                    if (flush) begin
                        flush_seen_q <= 1'b1;
                    end
                    if (icresp.ready) begin
                        cnt_q <= cnt_q + BEAT_W'(1);
                        if (icresp.last) begin
                            cnt_q <= '0;
                            // A flush seen anywhere in the burst leaves the line invalid.
                            if (!flush && !flush_seen_q) begin
                                valid_q[ref_idx] <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && state_q == REFILL && icresp.ready) begin
            data_mem[{ref_idx, cnt_q}] <= icresp.data;
            if (icresp.last) begin
                tag_mem[ref_idx] <= req_addr_q[31:TAG_LSB];
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic stat_hit;
    logic stat_miss;

    assign stat_hit  = (state_q == IDLE) && ireq.valid && ireq.addr[31] && lk_hit;
    assign stat_miss = (state_q == IDLE) && (state_d == REFILL);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (stat_hit && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + 64'd1;
            end
            if (stat_miss && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 64'd1;
            end
        end
    end
`endif

endmodule
